// File: rtl/fxp_div_pkg.sv
// Shared types and elaboration-time helpers for the sequential fixed-point divider.
// The saturation limits are computed here so the datapath and the saturation stage agree.
package fxp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest quotient magnitude supported: WIDTH 48 with FRAC 47.
    localparam int MAX_ITER = 96;
    typedef logic [MAX_ITER-1:0] wide_t;

    function automatic int n_iter(input int width, input int frac);
        return width + frac;
    endfunction

    // Largest positive result: 2^(W-1)-1 when signed, 2^W-1 when unsigned.
    function automatic wide_t pos_limit(input int width, input bit sgn);
        return sgn ? (wide_t'(1) << (width - 1)) - wide_t'(1)
                   : (wide_t'(1) << width) - wide_t'(1);
    endfunction

    // Magnitude of the most negative signed result, 2^(W-1).
    function automatic wide_t neg_limit(input int width);
        return wide_t'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/fxp_div_seq_sat_sign.sv
// Combinational sign application and saturation of the unsigned quotient magnitude.
// Also resolves the divide-by-zero result, which saturates toward the dividend's sign.
module fxp_sat_sign
    import fxp_div_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int N_ITER = 47,
    parameter bit SIGNED = 1'b1
) (
    input  logic [N_ITER-1:0] q,
    input  logic              neg,
    input  logic              dbz,
    input  logic              dividend_zero,
    output logic [WIDTH-1:0]  quotient,
    output logic              overflow,
    output logic              div_by_zero
);

    localparam logic [N_ITER-1:0] POS_LIM = N_ITER'(pos_limit(WIDTH, SIGNED));
    localparam logic [N_ITER-1:0] NEG_LIM = N_ITER'(neg_limit(WIDTH));

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        quotient    = '0;
        overflow    = 1'b0;
        div_by_zero = dbz;
        if (dbz) begin
            if (!dividend_zero) begin
                overflow = 1'b1;
                quotient = neg ? NEG_LIM[WIDTH-1:0] : POS_LIM[WIDTH-1:0];
            end
        end else if (neg) begin
            if (q > NEG_LIM) begin
                overflow = 1'b1;
                quotient = NEG_LIM[WIDTH-1:0];
            end else begin
                quotient = -q[WIDTH-1:0];
            end
        end else begin
            if (q > POS_LIM) begin
                overflow = 1'b1;
                quotient = POS_LIM[WIDTH-1:0];
            end else begin
                quotient = q[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/fxp_div_seq.sv
// Sequential radix-2 restoring fixed-point divider with valid/ready on both sides.
// One quotient bit per enabled cycle; en=0 freezes all state and blocks both handshakes.
module fxp_div_seq
    import fxp_div_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 15,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int N_ITER = n_iter(WIDTH, FRAC);
    localparam int CW     = $clog2(N_ITER + 1);

    state_t            state;
    logic [N_ITER-1:0] num;
    logic [N_ITER-1:0] quo;
    logic [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]  dmag;
    logic [CW-1:0]     cnt;
    logic              neg;
    logic              dbz;
    logic              dzero;

    logic              dividend_neg;
    logic              divisor_neg;
    logic [WIDTH-1:0]  dividend_mag;
    logic [WIDTH-1:0]  divisor_mag;
    logic [WIDTH:0]    rem_sh;
    logic [WIDTH-1:0]  rem_diff;
    logic              ge;
    logic [WIDTH-1:0]  rem_next;
    logic [N_ITER-1:0] quo_next;

    logic [WIDTH-1:0]  sat_q;
    logic              sat_ov;
    logic              sat_dbz;

    assign in_ready = en && rst_n && (state == IDLE);

    assign dividend_neg = SIGNED && dividend[WIDTH-1];
    assign divisor_neg  = SIGNED && divisor[WIDTH-1];
    assign dividend_mag = dividend_neg ? -dividend : dividend;
    assign divisor_mag  = divisor_neg  ? -divisor  : divisor;

    // The difference is only kept when rem_sh >= dmag, so it always fits WIDTH bits.
    assign rem_sh   = {rem, num[N_ITER-1]};
    assign ge       = rem_sh >= {1'b0, dmag};
    assign rem_diff = rem_sh[WIDTH-1:0] - dmag;
    assign rem_next = ge ? rem_diff : rem_sh[WIDTH-1:0];
    assign quo_next = {quo[N_ITER-2:0], ge};

    fxp_sat_sign #(
        .WIDTH (WIDTH),
        .N_ITER(N_ITER),
        .SIGNED(SIGNED)
    ) u_sat (
        .q            (quo_next),
        .neg          (neg),
        .dbz          (dbz),
        .dividend_zero(dzero),
        .quotient     (sat_q),
        .overflow     (sat_ov),
        .div_by_zero  (sat_dbz)
    );

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            num         <= '0;
            quo         <= '0;
            rem         <= '0;
            dmag        <= '0;
            cnt         <= '0;
            neg         <= 1'b0;
            dbz         <= 1'b0;
            dzero       <= 1'b0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        num   <= N_ITER'(dividend_mag) << FRAC;
                        dmag  <= divisor_mag;
                        neg   <= dividend_neg ^ divisor_neg;
                        dbz   <= (divisor_mag == '0);
                        dzero <= (dividend_mag == '0);
                        cnt   <= '0;
                        rem   <= '0;
                        quo   <= '0;
                        state <= (divisor_mag == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    num <= num << 1;
                    cnt <= cnt + 1'b1;
                    // The last iteration registers the result straight from the next-quotient path.
                    if (cnt == CW'(N_ITER - 1)) begin
                        quotient    <= sat_q;
                        overflow    <= sat_ov;
                        div_by_zero <= sat_dbz;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // Divide-by-zero arrives here without a result yet; capture it on the first cycle.
                    if (!out_valid) begin
                        quotient    <= sat_q;
                        overflow    <= sat_ov;
                        div_by_zero <= sat_dbz;
                        out_valid   <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
